ahb_timer_array: RTL
====================

# ahb_timer_array

AHB-Lite slave containing NUM_CH independent down-counter channels. Each channel runs in one of five modes: off, one-shot, periodic, watchdog or PWM. It generalises the single timer/WD/PWM slave to a parameterised channel count and counter width, adding per-channel interrupts, W1C status and error responses. It sits on the slave side of the AHB interconnect in the address region selected by the decoder.

## Interface
Parameters:
- DATA_WIDTH, 32: bus data width.
- ADDR_WIDTH, 32: bus address width. Only bits [8:0] are decoded.
- NUM_CH, 4: number of channels, 1..8.
- CNT_WIDTH, 16: counter, LOAD and THRES width, 1..DATA_WIDTH.

Ports:
- HCLK, in, 1: bus clock.
- wd_rst, in, 1: reset, asynchronous, active-high.
- HSEL, in, 1: slave select from the decoder.
- HADDR, in, ADDR_WIDTH: address.
- HTRANS, in, 2: transfer type.
- HWRITE, in, 1: 1 = write.
- HSIZE, in, 3: transfer size.
- HWDATA, in, DATA_WIDTH: write data.
- HREADY, in, 1: bus ready.
- HREADYOUT, out, 1: slave ready.
- HRDATA, out, DATA_WIDTH: read data.
- HRESP, out, 1: 0 = OKAY, 1 = ERROR.
- pwm_out, out, NUM_CH: PWM output, one bit per channel.
- irq, out, NUM_CH: level interrupt per channel, equal to status & irq_en.
- wd_expire, out, 1: one-cycle pulse when any watchdog channel expires.

## Operation
- Register map: channel c at base c*0x20.
  - +0x00 CTRL, RW: [2:0] mode (000 off, 001 one-shot, 010 periodic, 011 watchdog, 100 PWM); [3] irq_en.
  - +0x04 LOAD, RW.
  - +0x08 THRES, RW.
  - +0x0C COUNT, RO.
  - +0x10 STATUS: [0] expired, write-1-to-clear.
- Reads of unused bits return 0.
- Valid transfer: HSEL & HREADY & HTRANS ∈ {NONSEQ, SEQ}. IDLE and BUSY are ignored with a zero-wait OKAY.
- Address phase registers addr/write/valid. The data phase writes HWDATA or drives HRDATA.
- ERROR conditions:
  - channel index ≥ NUM_CH, or offset > 0x10, or HSIZE ≠ WORD;
  - write to COUNT.
- On ERROR, no register changes.
- Load event: a CTRL write with mode ≠ 000, or any LOAD write. The count is set to LOAD and status is left unchanged.
  - LOAD write while in watchdog mode = kick.
- Count: decrements by 1 per HCLK while mode ≠ 000 and count ≠ 0. When count = 0:
  - one-shot: status←1, mode←000, count holds 0.
  - periodic: status←1, count←LOAD.
  - watchdog: status←1, wd_expire pulses, mode←000.
  - PWM: count←LOAD, status unchanged.
- PWM: pwm_out = (mode==100) & (count < THRES).
  - THRES=0 → constant 0.
  - THRES > LOAD → constant 1.
- Mode 000 or an undefined mode: counter frozen, pwm_out 0.
- Simultaneous events:
  - W1C and a set of status in the same cycle: set wins.
  - Bus load event and reload in the same cycle: bus value wins.
- LOAD=0 in periodic or PWM: status sets every cycle; pwm_out is 0.

## Timing
- Reset values: all registers 0, HREADYOUT=1, HRESP=0, HRDATA=0, pwm_out=0, irq=0, wd_expire=0.
- wd_rst is asserted asynchronously. Mid-count reset clears all channels immediately.
- OKAY transfers have zero wait states. HRDATA is valid in the data-phase cycle.
- ERROR is two-cycle:
  - cycle 1: HREADYOUT=0, HRESP=1;
  - cycle 2: HREADYOUT=1, HRESP=1.
  - A transfer pipelined behind an ERROR is discarded.
- The register updates on the clock edge ending the data phase.
- With LOAD=N: count=N the cycle after the load event, reaches 0 N cycles later, and status sets on the following edge (N+2 edges after the write data phase).
- irq and pwm_out are registered-free combinational decodes of registered state.
- wd_expire is registered, high for exactly one cycle.

## Structure
- Package timer_pkg holds:
  - mode enum, register offsets, HTRANS/HSIZE/HRESP enums;
  - CH_STRIDE = 0x20.
- Sub-module timer_channel, instantiated NUM_CH times:
  - inputs: ctrl/load/thres, load_evt, w1c;
  - outputs: count, status, pwm, expire.
- The top-level module holds the AHB address-phase register, decode, the ERROR FSM (IDLE → ERR1 → ERR2 → IDLE), the read mux and the wd_expire OR-reduction.

## Test plan
- Write LOAD0=5 then CTRL0=001: status0=1 and COUNT0=0 after 7 edges; CTRL0 mode reads 000.
- Periodic on ch1 with LOAD=3 and irq_en=1: irq[1] rises; W1C to STATUS1 clears it; it sets again 4 cycles later.
- Watchdog on ch2 with LOAD=10: kick at count 2 → no wd_expire; no kick → exactly one cycle of wd_expire.
- PWM on ch3 with LOAD=9, THRES=4: pwm_out[3] high 4 of every 10 cycles; THRES=0 → constant low.
- Read 0x80 with NUM_CH=4, write COUNT0, read with HSIZE=BYTE: each gives a two-cycle ERROR and registers are unchanged.
- wd_rst pulsed mid-count on all channels: all outputs and registers are 0 asynchronously; a BUSY transfer gets zero-wait OKAY.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the AHB timer array: channel modes, AHB encodings,
// register offsets and the per-channel address stride.
package timer_pkg;

    typedef enum logic [2:0] {
        ModeOff      = 3'b000,
        ModeOneShot  = 3'b001,
        ModePeriodic = 3'b010,
        ModeWatchdog = 3'b011,
        ModePwm      = 3'b100
    } mode_e;

    typedef enum logic [1:0] {
        TransIdle   = 2'b00,
        TransBusy   = 2'b01,
        TransNonseq = 2'b10,
        TransSeq    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        SizeByte = 3'b000,
        SizeHalf = 3'b001,
        SizeWord = 3'b010
    } hsize_e;

    typedef enum logic {
        RespOkay  = 1'b0,
        RespError = 1'b1
    } hresp_e;

    typedef enum logic [1:0] {
        StIdle,
        StErr1,
        StErr2
    } err_state_e;

    localparam int unsigned CH_STRIDE = 32'h20;
    localparam int unsigned CH_SHIFT  = $clog2(CH_STRIDE);
    localparam int unsigned CH_IDX_W  = 9 - CH_SHIFT;

    localparam logic [4:0] OFF_CTRL   = 5'h00;
    localparam logic [4:0] OFF_LOAD   = 5'h04;
    localparam logic [4:0] OFF_THRES  = 5'h08;
    localparam logic [4:0] OFF_COUNT  = 5'h0C;
    localparam logic [4:0] OFF_STATUS = 5'h10;

    function automatic logic mode_active(input logic [2:0] m);
        return (m == ModeOneShot) || (m == ModePeriodic) || (m == ModeWatchdog) ||
               (m == ModePwm);
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One down-counter channel (off / one-shot / periodic / watchdog / PWM) owning its
// CTRL, LOAD, THRES, COUNT and STATUS registers.
module timer_channel
    import timer_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 wd_rst_i,
    input  logic                 ctrl_we_i,
    input  logic                 load_we_i,
    input  logic                 thres_we_i,
    input  logic                 load_evt_i,
    input  logic                 w1c_i,
    input  logic [3:0]           ctrl_wdata_i,
    input  logic [CNT_WIDTH-1:0] cnt_wdata_i,
    output logic [3:0]           ctrl_o,
    output logic [CNT_WIDTH-1:0] load_o,
    output logic [CNT_WIDTH-1:0] thres_o,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 status_o,
    output logic                 pwm_o,
    output logic                 expire_o
);

    logic [2:0]           mode_q, mode_d;
    logic                 irq_en_q, irq_en_d;
    logic [CNT_WIDTH-1:0] load_q, load_d;
    logic [CNT_WIDTH-1:0] thres_q, thres_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 status_q, status_d;

    always_ff @(posedge clk_i or posedge wd_rst_i) begin
        if (wd_rst_i) begin
            mode_q   <= ModeOff;
            irq_en_q <= 1'b0;
            load_q   <= '0;
            thres_q  <= '0;
            count_q  <= '0;
            status_q <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            irq_en_q <= irq_en_d;
            load_q   <= load_d;
            thres_q  <= thres_d;
            count_q  <= count_d;
            status_q <= status_d;
        end
    end

    always_comb begin
        mode_d   = mode_q;
        irq_en_d = irq_en_q;
        load_d   = load_q;
        thres_d  = thres_q;
        count_d  = count_q;
        status_d = status_q;
        expire_o = 1'b0;

        // Clear first so a same-cycle expiry still sets the flag.
        if (w1c_i) status_d = 1'b0;

        if (mode_active(mode_q)) begin
            if (count_q != '0) begin
                count_d = count_q - CNT_WIDTH'(1);
            end else begin
                unique case (mode_q)
                    ModeOneShot: begin
                        status_d = 1'b1;
                        mode_d   = ModeOff;
                    end
                    ModePeriodic: begin
                        status_d = 1'b1;
                        count_d  = load_q;
                    end
                    ModeWatchdog: begin
                        status_d = 1'b1;
                        mode_d   = ModeOff;
                        expire_o = 1'b1;
                    end
                    ModePwm: begin
                        count_d = load_q;
                        if (load_q == '0) status_d = 1'b1;
                    end
                    default: ;
                endcase
            end
        end

        // Bus writes come last so they override reload and expiry.
        if (ctrl_we_i) begin
            mode_d   = ctrl_wdata_i[2:0];
            irq_en_d = ctrl_wdata_i[3];
        end
        if (load_we_i)  load_d  = cnt_wdata_i;
        if (thres_we_i) thres_d = cnt_wdata_i;
        if (load_evt_i) count_d = load_we_i ? cnt_wdata_i : load_q;
    end

    assign ctrl_o   = {irq_en_q, mode_q};
    assign load_o   = load_q;
    assign thres_o  = thres_q;
    assign count_o  = count_q;
    assign status_o = status_q;
    assign pwm_o    = (mode_q == ModePwm) && (count_q < thres_q) && (load_q != '0);

endmodule

// File: rtl/ahb_timer_array.sv
// AHB-Lite slave fronting NUM_CH timer channels: address-phase capture, decode,
// two-cycle ERROR response, read mux and the registered watchdog-expiry pulse.
module ahb_timer_array
    import timer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  HCLK,
    input  logic                  wd_rst,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HRESP,
    output logic [NUM_CH-1:0]     pwm_out,
    output logic [NUM_CH-1:0]     irq,
    output logic                  wd_expire
);

    err_state_e          state_q, state_d;
    logic                dph_valid_q, dph_valid_d;
    logic                dph_write_q, dph_write_d;
    logic [CH_IDX_W-1:0] dph_ch_q, dph_ch_d;
    logic [2:0]          dph_reg_q, dph_reg_d;
    logic                wd_expire_q, wd_expire_d;

    logic [CH_IDX_W-1:0] a_ch;
    logic [4:0]          a_off;
    logic                a_valid, a_err, wr_en;
    logic                unused_bus;

    logic [3:0]           ctrl_w   [NUM_CH];
    logic [CNT_WIDTH-1:0] load_w   [NUM_CH];
    logic [CNT_WIDTH-1:0] thres_w  [NUM_CH];
    logic [CNT_WIDTH-1:0] count_w  [NUM_CH];
    logic [NUM_CH-1:0]    status_w, expire_w;

    assign a_ch  = HADDR[8:CH_SHIFT];
    assign a_off = HADDR[CH_SHIFT-1:0];
    // Transfers arriving while an ERROR is in progress are dropped.
    assign a_valid = HSEL && HREADY && HTRANS[1] && (state_q == StIdle);
    assign a_err   = (32'(a_ch) >= NUM_CH) || (a_off > OFF_STATUS) || (HSIZE != SizeWord) ||
                     (HWRITE && (a_off[4:2] == OFF_COUNT[4:2]));
    assign wr_en   = dph_valid_q && dph_write_q;
    assign unused_bus = ^{HADDR, HWDATA, HTRANS};

    always_ff @(posedge HCLK or posedge wd_rst) begin
        if (wd_rst) begin
            state_q     <= StIdle;
            dph_valid_q <= 1'b0;
            dph_write_q <= 1'b0;
            dph_ch_q    <= '0;
            dph_reg_q   <= '0;
            wd_expire_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dph_valid_q <= dph_valid_d;
            dph_write_q <= dph_write_d;
            dph_ch_q    <= dph_ch_d;
            dph_reg_q   <= dph_reg_d;
            wd_expire_q <= wd_expire_d;
        end
    end

    always_comb begin
        dph_valid_d = a_valid && !a_err;
        dph_write_d = dph_write_q;
        dph_ch_d    = dph_ch_q;
        dph_reg_d   = dph_reg_q;
        if (a_valid) begin
            dph_write_d = HWRITE;
            dph_ch_d    = a_ch;
            dph_reg_d   = a_off[4:2];
        end
        wd_expire_d = |expire_w;
    end

    always_comb begin
        state_d   = state_q;
        HREADYOUT = 1'b1;
        HRESP     = RespOkay;
        unique case (state_q)
            StIdle: if (a_valid && a_err) state_d = StErr1;
            StErr1: begin
                state_d   = StErr2;
                HREADYOUT = 1'b0;
                HRESP     = RespError;
            end
            StErr2: begin
                state_d = StIdle;
                HRESP   = RespError;
            end
            default: state_d = StIdle;
        endcase
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [CH_IDX_W-1:0] ChIdx = CH_IDX_W'(c);
        logic sel, ctrl_we, load_we, thres_we, w1c, load_evt;

        assign sel      = wr_en && (dph_ch_q == ChIdx);
        assign ctrl_we  = sel && (dph_reg_q == OFF_CTRL[4:2]);
        assign load_we  = sel && (dph_reg_q == OFF_LOAD[4:2]);
        assign thres_we = sel && (dph_reg_q == OFF_THRES[4:2]);
        assign w1c      = sel && (dph_reg_q == OFF_STATUS[4:2]) && HWDATA[0];
        assign load_evt = load_we || (ctrl_we && (HWDATA[2:0] != ModeOff));

        timer_channel #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_channel (
            .clk_i       (HCLK),
            .wd_rst_i    (wd_rst),
            .ctrl_we_i   (ctrl_we),
            .load_we_i   (load_we),
            .thres_we_i  (thres_we),
            .load_evt_i  (load_evt),
            .w1c_i       (w1c),
            .ctrl_wdata_i(HWDATA[3:0]),
            .cnt_wdata_i (HWDATA[CNT_WIDTH-1:0]),
            .ctrl_o      (ctrl_w[c]),
            .load_o      (load_w[c]),
            .thres_o     (thres_w[c]),
            .count_o     (count_w[c]),
            .status_o    (status_w[c]),
            .pwm_o       (pwm_out[c]),
            .expire_o    (expire_w[c])
        );

        assign irq[c] = status_w[c] && ctrl_w[c][3];
    end

    always_comb begin
        HRDATA = '0;
        if (dph_valid_q && !dph_write_q) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (dph_ch_q == CH_IDX_W'(c)) begin
                    case (dph_reg_q)
                        OFF_CTRL[4:2]:   HRDATA[3:0]           = ctrl_w[c];
                        OFF_LOAD[4:2]:   HRDATA[CNT_WIDTH-1:0] = load_w[c];
                        OFF_THRES[4:2]:  HRDATA[CNT_WIDTH-1:0] = thres_w[c];
                        OFF_COUNT[4:2]:  HRDATA[CNT_WIDTH-1:0] = count_w[c];
                        OFF_STATUS[4:2]: HRDATA[0]             = status_w[c];
                        default: ;
                    endcase
                end
            end
        end
    end

    assign wd_expire = wd_expire_q;

endmodule
